// File: rtl/ham2d_pkg.sv
// Shared constants, FSM state type and Hamming helper functions for the 2D
// product-code decoder (Hamming(15,11) columns, Hamming(7,4) rows).
`default_nettype none

package ham2d_pkg;

  localparam int COL_N       = 15;
  localparam int COL_K       = 11;
  localparam int ROW_N       = 7;
  localparam int ROW_K       = 4;
  localparam int GROUP_IN_W  = 105;
  localparam int GROUP_OUT_W = 44;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DONE   = 2'd2
  } ham2d_state_e;

  // Bit k-1 of a codeword is position k; the syndrome is the XOR of set positions.
  function automatic logic [3:0] ham_syndrome15(input logic [COL_N-1:0] cw);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k <= COL_N; k++) begin
      if (cw[k-1]) s = s ^ 4'(k);
    end
    return s;
  endfunction

  function automatic logic [2:0] ham_syndrome7(input logic [ROW_N-1:0] cw);
    logic [2:0] s;
    s = '0;
    for (int k = 1; k <= ROW_N; k++) begin
      if (cw[k-1]) s = s ^ 3'(k);
    end
    return s;
  endfunction

  // Data bits live at the non-power-of-two positions, in ascending order.
  function automatic logic [COL_K-1:0] ham_data15(input logic [COL_N-1:0] cw);
    return {cw[14:8], cw[6:4], cw[2]};
  endfunction

  function automatic logic [ROW_K-1:0] ham_data7(input logic [ROW_N-1:0] cw);
    return {cw[6:4], cw[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ham2d_group_decoder.sv
// Combinational decode of one group: 7 column codewords, then 11 row codewords,
// yielding 44 data bits and the count of columns/rows that needed a correction.
`default_nettype none

module ham2d_group_decoder
  import ham2d_pkg::*;
(
  input  logic [GROUP_IN_W-1:0]  group_i,
  output logic [GROUP_OUT_W-1:0] data_o,
  output logic [2:0]             col_err_o,
  output logic [3:0]             row_err_o
);

  logic [COL_K-1:0][ROW_N-1:0] mat;
  logic [COL_N-1:0]            cw;
  logic [COL_K-1:0]            cd;
  logic [ROW_N-1:0]            rw;
  logic [3:0]                  s15;
  logic [2:0]                  s7;

  always_comb begin
    data_o    = '0;
    col_err_o = '0;
    row_err_o = '0;
    mat       = '0;
    cw        = '0;
    cd        = '0;
    rw        = '0;
    s15       = '0;
    s7        = '0;
    // Column c feeds position c+1 of every row codeword.
    for (int c = 0; c < ROW_N; c++) begin
      cw  = group_i[c*COL_N +: COL_N];
      s15 = ham_syndrome15(cw);
      if (s15 != 4'd0) begin
        cw        = cw ^ (15'd1 << (s15 - 4'd1));
        col_err_o = col_err_o + 3'd1;
      end
      cd = ham_data15(cw);
      for (int r = 0; r < COL_K; r++) begin
        mat[r][c] = cd[r];
      end
    end
    for (int r = 0; r < COL_K; r++) begin
      rw = mat[r];
      s7 = ham_syndrome7(rw);
      if (s7 != 3'd0) begin
        rw        = rw ^ (7'd1 << (s7 - 3'd1));
        row_err_o = row_err_o + 4'd1;
      end
      data_o[r*ROW_K +: ROW_K] = ham_data7(rw);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_2d_stream_decoder.sv
// Block-level 2D Hamming product decoder: one group per cycle through a shared
// group datapath. Optional cumulative stats enabled by HAM2D_ERR_STATS_EN.
`default_nettype none

module hamming_2d_stream_decoder
  import ham2d_pkg::*;
#(
  parameter int NUM_GROUPS = 1,
  parameter int CNT_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [GROUP_IN_W*NUM_GROUPS-1:0]  in_block,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [GROUP_OUT_W*NUM_GROUPS-1:0] out_data,
`ifdef HAM2D_ERR_STATS_EN
  input  logic                              clr_stats,
  output logic [31:0]                       stat_col_total,
  output logic [31:0]                       stat_row_total,
`endif
  output logic [CNT_W-1:0]                  out_col_corr,
  output logic [CNT_W-1:0]                  out_row_corr
);

  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);

  if (NUM_GROUPS < 1 || CNT_W < 4 ||
      (CNT_W < 31 && (11 * NUM_GROUPS) > ((1 << CNT_W) - 1))) begin : g_bad_params
    $fatal(1, "hamming_2d_stream_decoder: CNT_W too small for 11*NUM_GROUPS");
  end

  ham2d_state_e                      state_q, state_d;
  logic [GW-1:0]                     g_q, g_d;
  logic [GROUP_IN_W*NUM_GROUPS-1:0]  block_q, block_d;
  logic [GROUP_OUT_W*NUM_GROUPS-1:0] data_q, data_d;
  logic [CNT_W-1:0]                  col_q, col_d, row_q, row_d;

  logic [GROUP_IN_W-1:0]  grp_in;
  logic [GROUP_OUT_W-1:0] grp_data;
  logic [2:0]             grp_col;
  logic [3:0]             grp_row;

  always_comb begin
    grp_in = block_q[GROUP_IN_W-1:0];
    for (int g = 1; g < NUM_GROUPS; g++) begin
      if (g_q == GW'(g)) grp_in = block_q[g*GROUP_IN_W +: GROUP_IN_W];
    end
  end

  ham2d_group_decoder u_group (
    .group_i   (grp_in),
    .data_o    (grp_data),
    .col_err_o (grp_col),
    .row_err_o (grp_row)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    block_d = block_q;
    data_d  = data_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          block_d = in_block;
          g_d     = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
          if (g_q == GW'(g)) data_d[g*GROUP_OUT_W +: GROUP_OUT_W] = grp_data;
        end
        col_d = col_q + CNT_W'(grp_col);
        row_d = row_q + CNT_W'(grp_row);
        if (g_q == G_LAST) state_d = ST_DONE;
        else               g_d     = g_q + GW'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      block_q <= '0;
      data_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      block_q <= block_d;
      data_q  <= data_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_data     = data_q;
  assign out_col_corr = col_q;
  assign out_row_corr = row_q;

`ifdef HAM2D_ERR_STATS_EN
  logic [31:0] stat_col_q, stat_row_q;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [CNT_W-1:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(b);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // A clear wins over a block completing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_col_q <= '0;
      stat_row_q <= '0;
    end else if (clr_stats) begin
      stat_col_q <= '0;
      stat_row_q <= '0;
    end else if (out_valid && out_ready) begin
      stat_col_q <= sat_add32(stat_col_q, col_q);
      stat_row_q <= sat_add32(stat_row_q, row_q);
    end
  end

  assign stat_col_total = stat_col_q;
  assign stat_row_total = stat_row_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hamming_2d_stream_decoder.sv
// Randomised self-checking bench: two decoder instances (1 and 2 groups) checked
// against an encoder/error-injection model built from the code definition.
`default_nettype none

module tb_hamming_2d_stream_decoder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_v = 1'b0;
  logic         which = 1'b0;
  logic [209:0] in_blk = '0;
  logic         out_rdy = 1'b0;
  logic         clr = 1'b0;

  logic         in_rdy_a, in_rdy_b, ov_a, ov_b;
  logic [43:0]  od_a;
  logic [87:0]  od_b;
  logic [7:0]   cc_a, cc_b, rc_a, rc_b;
`ifdef HAM2D_ERR_STATS_EN
  logic [31:0]  sc_a, sr_a, sc_b, sr_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_2d_stream_decoder #(.NUM_GROUPS(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_v & ~which), .in_ready(in_rdy_a),
    .in_block(in_blk[104:0]), .out_valid(ov_a), .out_ready(out_rdy), .out_data(od_a),
`ifdef HAM2D_ERR_STATS_EN
    .clr_stats(clr), .stat_col_total(sc_a), .stat_row_total(sr_a),
`endif
    .out_col_corr(cc_a), .out_row_corr(rc_a)
  );

  hamming_2d_stream_decoder #(.NUM_GROUPS(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_v & which), .in_ready(in_rdy_b),
    .in_block(in_blk), .out_valid(ov_b), .out_ready(out_rdy), .out_data(od_b),
`ifdef HAM2D_ERR_STATS_EN
    .clr_stats(clr), .stat_col_total(sc_b), .stat_row_total(sr_b),
`endif
    .out_col_corr(cc_b), .out_row_corr(rc_b)
  );

  wire        in_rdy_m = which ? in_rdy_b : in_rdy_a;
  wire        ov_m     = which ? ov_b : ov_a;
  wire [87:0] od_m     = which ? od_b : {44'b0, od_a};
  wire [7:0]  cc_m     = which ? cc_b : cc_a;
  wire [7:0]  rc_m     = which ? rc_b : rc_a;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Systematic Hamming(n,k) encoder straight from the position rules.
  function automatic int ham_enc(input int n, input int data);
    int cw, s, j;
    cw = 0; s = 0; j = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((data >> j) & 1) == 1) begin
          cw = cw | (1 << (p - 1));
          s  = s ^ p;
        end
        j++;
      end
    end
    for (int b = 1; b <= n; b = b * 2) begin
      if ((s & b) != 0) cw = cw | (1 << (b - 1));
    end
    return cw;
  endfunction

  function automatic logic [104:0] encode_group(input logic [43:0] d);
    logic [104:0] g;
    int rc [11];
    int cd;
    g = '0;
    for (int r = 0; r < 11; r++) rc[r] = ham_enc(7, int'(d[r*4 +: 4]));
    for (int c = 0; c < 7; c++) begin
      cd = 0;
      for (int r = 0; r < 11; r++) begin
        if (((rc[r] >> c) & 1) == 1) cd = cd | (1 << r);
      end
      g[c*15 +: 15] = 15'(ham_enc(15, cd));
    end
    return g;
  endfunction

  task automatic xfer(input logic w, input logic [209:0] blk, input int hold,
                      input logic [87:0] exp_d, input int exp_c, input int exp_r,
                      input logic clr_at_hs);
    int n;
    int grps;
    logic [87:0] first;
    grps    = w ? 2 : 1;
    which   = w;
    in_blk  = blk;
    in_v    = 1'b1;
    out_rdy = 1'b0;
    n = 0;
    while (!in_rdy_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", n, 0);
    if (!in_rdy_m) begin
      in_v = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Keep in_valid high with junk while busy: it must be ignored.
    in_blk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ov_m) check_eq("busy_ready", in_rdy_m, 0);
    end while (!ov_m && n < 20);
    in_v = 1'b0;
    check_eq("latency", n, grps + 1);
    first = od_m;
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", ov_m, 1);
      check_eq("hold_ready", in_rdy_m, 0);
      check_eq("hold_data", od_m, first);
      @(negedge clk);
    end
    check_eq("valid", ov_m, 1);
    check_eq("data", od_m, exp_d);
    check_eq("col_corr", cc_m, exp_c);
    check_eq("row_corr", rc_m, exp_r);
    out_rdy = 1'b1;
    clr     = clr_at_hs;
    @(negedge clk);
    out_rdy = 1'b0;
    clr     = 1'b0;
    check_eq("post_valid", ov_m, 0);
    check_eq("post_ready", in_rdy_m, 1);
  endtask

  logic [87:0]  d;
  logic [209:0] blk;
  int           nc, nr;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_a", in_rdy_a, 1);
    check_eq("rst_ready_b", in_rdy_b, 1);
    check_eq("rst_valid", {ov_a, ov_b}, 0);
    check_eq("rst_data", {od_a, od_b}, 0);
    check_eq("rst_cnts", {cc_a, rc_a, cc_b, rc_b}, 0);

    // All-zero block, one group.
    xfer(1'b0, '0, 0, '0, 0, 0, 1'b0);

    // Single error in column 3, position 5.
    d   = {44'b0, 44'h1234_5678_9AB};
    blk = {105'b0, encode_group(d[43:0])};
    blk[3*15 + 4] = ~blk[3*15 + 4];
    xfer(1'b0, blk, 0, d, 1, 0, 1'b0);

    // Double error in column 2 (positions 3 and 6): column miscorrects, rows repair.
    blk = {105'b0, encode_group(d[43:0])};
    blk[2*15 + 2] = ~blk[2*15 + 2];
    blk[2*15 + 5] = ~blk[2*15 + 5];
    xfer(1'b0, blk, 0, d, 1, 3, 1'b0);

    // Two groups back to back with a stalled output.
    d   = {$urandom(), $urandom(), $urandom()};
    blk = {encode_group(d[87:44]), encode_group(d[43:0])};
    blk[105 + 6*15 + 14] = ~blk[105 + 6*15 + 14];
    xfer(1'b1, blk, 5, d, 1, 0, 1'b0);
    d   = {$urandom(), $urandom(), $urandom()};
    blk = {encode_group(d[87:44]), encode_group(d[43:0])};
    xfer(1'b1, blk, 5, d, 0, 0, 1'b0);

    // Reset while decoding group 1.
    which  = 1'b1;
    in_blk = {encode_group(44'h0FF), encode_group(44'h123)};
    in_v   = 1'b1;
    @(posedge clk);
    #1 in_v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", ov_b, 0);
    check_eq("midrst_ready", in_rdy_b, 1);
    check_eq("midrst_data", od_b, 0);
    check_eq("midrst_cnts", {cc_b, rc_b}, 0);
    d   = {44'hABC_DEF0_1234, 44'h0_5555_AAAA};
    blk = {encode_group(d[87:44]), encode_group(d[43:0])};
    xfer(1'b1, blk, 0, d, 0, 0, 1'b0);

    // Random data with at most one flipped bit per column.
    for (int i = 0; i < 16; i++) begin
      logic w;
      w  = 1'($urandom_range(0, 1));
      d  = {$urandom(), $urandom(), $urandom()};
      if (!w) d[87:44] = '0;
      blk = {encode_group(d[87:44]), encode_group(d[43:0])};
      nc = 0;
      for (int g = 0; g < (w ? 2 : 1); g++) begin
        for (int c = 0; c < 7; c++) begin
          if ($urandom_range(0, 1) == 1) begin
            int p;
            p = int'($urandom_range(0, 14));
            blk[g*105 + c*15 + p] = ~blk[g*105 + c*15 + p];
            nc++;
          end
        end
      end
      nr = 0;
      xfer(w, blk, int'($urandom_range(0, 2)), d, nc, nr, 1'b0);
    end

`ifdef HAM2D_ERR_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("stat_rst", sc_a, 0);
    for (int i = 0; i < 3; i++) begin
      d   = {44'b0, 44'($urandom())};
      blk = {105'b0, encode_group(d[43:0])};
      blk[i*15 + 7] = ~blk[i*15 + 7];
      xfer(1'b0, blk, 0, d, 1, 0, 1'b0);
    end
    check_eq("stat_col_total", sc_a, 3);
    check_eq("stat_row_total", sr_a, 0);
    d   = {44'b0, 44'h3C3};
    blk = {105'b0, encode_group(d[43:0])};
    blk[0] = ~blk[0];
    xfer(1'b0, blk, 0, d, 1, 0, 1'b1);
    check_eq("stat_clr", sc_a, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
